// File: rtl/qix_shram_arbiter.sv
// Qix shared-RAM arbiter: one 2^ADDR_W x DATA_W RAM time-shared by data CPU (a_), video CPU (b_)
// and an optional low-priority hiscore port (hs_), enabled by defining QIX_SHRAM_HS_EN.
module qix_shram_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic              clk_20m,
    input  logic              reset,

    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_din,
    output logic [DATA_W-1:0] a_dout,
    output logic              a_ack,

    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_din,
    output logic [DATA_W-1:0] b_dout,
    output logic              b_ack,

    input  logic              hs_req,
    input  logic              hs_we,
    input  logic [ADDR_W-1:0] hs_addr,
    input  logic [DATA_W-1:0] hs_din,
    output logic [DATA_W-1:0] hs_dout,
    output logic              hs_ack,

    output logic              busy
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, ACK = 2'd2} state_t;
    typedef enum logic [1:0] {SEL_A = 2'd0, SEL_B = 2'd1, SEL_HS = 2'd2} sel_t;

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state;
    sel_t              sel;
    sel_t              win;
    logic              last_b;
    logic              any_req;
    logic              hs_req_en;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_din;
    logic [DATA_W-1:0] rsp;
    logic              hs_ack_r;
    logic [DATA_W-1:0] hs_dout_r;

`ifdef QIX_SHRAM_HS_EN
    assign hs_req_en = hs_req;
    assign hs_ack    = hs_ack_r;
    assign hs_dout   = hs_dout_r;
`else
    // Hiscore port kept for wiring compatibility only; its inputs are ignored.
    logic unused_hs;
    assign hs_req_en = 1'b0;
    assign hs_ack    = 1'b0;
    assign hs_dout   = '0;
    assign unused_hs = &{1'b0, hs_req, hs_we, hs_addr, hs_din, hs_ack_r, hs_dout_r};
`endif

    // A/B round-robin on last_b; hiscore only when both CPUs are idle.
    always_comb begin
        any_req = a_req | b_req | hs_req_en;
        win     = SEL_HS;
        if (a_req && b_req) begin
            win = last_b ? SEL_A : SEL_B;
        end else if (a_req) begin
            win = SEL_A;
        end else if (b_req) begin
            win = SEL_B;
        end
    end

    // A write echoes its own data back as the response.
    assign rsp = lat_we ? lat_din : mem[lat_addr];

    always_ff @(posedge clk_20m) begin
        if (!reset && state == GRANT && lat_we) begin
            mem[lat_addr] <= lat_din;
        end
    end

    always_ff @(posedge clk_20m) begin
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            last_b    <= 1'b1;
            a_ack     <= 1'b0;
            b_ack     <= 1'b0;
            hs_ack_r  <= 1'b0;
            a_dout    <= '0;
            b_dout    <= '0;
            hs_dout_r <= '0;
        end else begin
            a_ack    <= 1'b0;
            b_ack    <= 1'b0;
            hs_ack_r <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        sel   <= win;
                        state <= GRANT;
                        busy  <= 1'b1;
                        case (win)
                            SEL_A: begin
                                lat_we   <= a_we;
                                lat_addr <= a_addr;
                                lat_din  <= a_din;
                                last_b   <= 1'b0;
                            end
                            SEL_B: begin
                                lat_we   <= b_we;
                                lat_addr <= b_addr;
                                lat_din  <= b_din;
                                last_b   <= 1'b1;
                            end
                            default: begin
                                lat_we   <= hs_we;
                                lat_addr <= hs_addr;
                                lat_din  <= hs_din;
                            end
                        endcase
                    end
                end
                GRANT: begin
                    state <= ACK;
                    case (sel)
                        SEL_A: begin
                            a_ack  <= 1'b1;
                            a_dout <= rsp;
                        end
                        SEL_B: begin
                            b_ack  <= 1'b1;
                            b_dout <= rsp;
                        end
                        default: begin
                            hs_ack_r  <= 1'b1;
                            hs_dout_r <= rsp;
                        end
                    endcase
                end
                ACK: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_qix_shram_arbiter.sv
// Directed bench for qix_shram_arbiter: per-port scoreboard queues hold expected dout and ack latency.
module tb_qix_shram_arbiter;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 8;

    typedef struct {
        logic [DATA_W-1:0] dout;
        int                lat;
    } exp_t;

    logic              clk_20m = 1'b0;
    logic              reset   = 1'b1;
    logic              req  [3];
    logic              we   [3];
    logic [ADDR_W-1:0] addr [3];
    logic [DATA_W-1:0] din  [3];
    logic [DATA_W-1:0] dout [3];
    logic              ack  [3];
    logic              busy;

    exp_t  q [3][$];
    int    cyc;
    int    t0      [3];
    int    drop_at [3];
    int    hold    [3];
    int    n_checks;
    int    n_fails;
    string pname   [3] = '{"a", "b", "hs"};

    always #5 clk_20m = ~clk_20m;

    qix_shram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk_20m (clk_20m),
        .reset   (reset),
        .a_req   (req[0]),
        .a_we    (we[0]),
        .a_addr  (addr[0]),
        .a_din   (din[0]),
        .a_dout  (dout[0]),
        .a_ack   (ack[0]),
        .b_req   (req[1]),
        .b_we    (we[1]),
        .b_addr  (addr[1]),
        .b_din   (din[1]),
        .b_dout  (dout[1]),
        .b_ack   (ack[1]),
        .hs_req  (req[2]),
        .hs_we   (we[2]),
        .hs_addr (addr[2]),
        .hs_din  (din[2]),
        .hs_dout (dout[2]),
        .hs_ack  (ack[2]),
        .busy    (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_20m);
        #1;
        cyc++;
    endtask

    task automatic expect_acc(input int p, input logic w, input logic [ADDR_W-1:0] ad,
                              input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] e, input int lat);
        exp_t ent;
        we[p]   = w;
        addr[p] = ad;
        din[p]  = d;
        t0[p]   = cyc;
        req[p]  = 1'b1;
        ent.dout = e;
        ent.lat  = lat;
        q[p].push_back(ent);
    endtask

    task automatic check_acks();
        exp_t e;
        for (int p = 0; p < 3; p++) begin
            if (ack[p] === 1'b1) begin
                check($sformatf("%s_ack_expected", pname[p]), 32'(q[p].size() != 0), 32'd1);
                if (q[p].size() != 0) begin
                    e = q[p].pop_front();
                    check($sformatf("%s_dout", pname[p]), 32'(dout[p]), 32'(e.dout));
                    check($sformatf("%s_ack_latency", pname[p]), 32'(cyc - t0[p]), 32'(e.lat));
                end
                if (hold[p] > 0) begin
                    drop_at[p] = cyc + 2;
                    hold[p]    = 0;
                end else begin
                    req[p] = 1'b0;
                end
            end else if (drop_at[p] == cyc) begin
                req[p]     = 1'b0;
                drop_at[p] = -1;
            end
        end
    endtask

    task automatic serve(input int budget);
        int n = 0;
        while ((q[0].size() + q[1].size() + q[2].size()) != 0 && n < budget) begin
            step();
            n++;
            check_acks();
        end
        check("serve_complete", 32'(q[0].size() + q[1].size() + q[2].size()), 32'd0);
        step();
        check_acks();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t ent;
        cyc = 0;
        n_checks = 0;
        n_fails = 0;
        for (int p = 0; p < 3; p++) begin
            req[p] = 1'b0; we[p] = 1'b0; addr[p] = '0; din[p] = '0;
            t0[p] = 0; drop_at[p] = -1; hold[p] = 0;
        end

        // Reset state
        reset = 1'b1;
        repeat (3) step();
        check("reset_a_ack", 32'(ack[0]), 32'd0);
        check("reset_b_ack", 32'(ack[1]), 32'd0);
        check("reset_hs_ack", 32'(ack[2]), 32'd0);
        check("reset_a_dout", 32'(dout[0]), 32'd0);
        check("reset_b_dout", 32'(dout[1]), 32'd0);
        check("reset_hs_dout", 32'(dout[2]), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        step();

        // A writes 0x5A to 0x123, B reads it back
        expect_acc(0, 1'b1, 10'h123, 8'h5A, 8'h5A, 2);
        step();
        check("busy_grant", 32'(busy), 32'd1);
        serve(10);
        check("busy_idle", 32'(busy), 32'd0);
        expect_acc(1, 1'b0, 10'h123, 8'h00, 8'h5A, 2);
        serve(10);

        // Tie with B granted last: A first at +2, B at +5
        expect_acc(0, 1'b1, 10'h010, 8'h33, 8'h33, 2);
        expect_acc(1, 1'b0, 10'h123, 8'h00, 8'h5A, 5);
        serve(12);

        // Solo A grant, then a tie goes to B first
        expect_acc(0, 1'b1, 10'h020, 8'h44, 8'h44, 2);
        serve(10);
        expect_acc(0, 1'b0, 10'h020, 8'h00, 8'h44, 5);
        expect_acc(1, 1'b0, 10'h010, 8'h00, 8'h33, 2);
        serve(12);

        // A holds req one extra cycle: second access, ack 3 cycles after the first
        expect_acc(0, 1'b0, 10'h010, 8'h00, 8'h33, 2);
        ent.dout = 8'h33;
        ent.lat  = 5;
        q[0].push_back(ent);
        hold[0] = 1;
        serve(12);

        // Hiscore request held under CPU traffic (last grant was A, so B wins the tie)
        we[2] = 1'b0;
        addr[2] = 10'h123;
`ifdef QIX_SHRAM_HS_EN
        expect_acc(2, 1'b0, 10'h123, 8'h00, 8'h5A, 8);
`else
        req[2] = 1'b1;
`endif
        expect_acc(0, 1'b0, 10'h123, 8'h00, 8'h5A, 5);
        expect_acc(1, 1'b0, 10'h020, 8'h00, 8'h44, 2);
        serve(16);
`ifndef QIX_SHRAM_HS_EN
        for (int i = 0; i < 100; i++) begin
            step();
            check_acks();
            check("hs_disabled_quiet", {23'd0, ack[2], dout[2]}, 32'd0);
        end
        req[2] = 1'b0;
`endif

        // Seed 0x000 with 0x11, then abort a write of 0xFF with reset during GRANT
        expect_acc(0, 1'b1, 10'h000, 8'h11, 8'h11, 2);
        serve(10);
        we[0] = 1'b1;
        addr[0] = 10'h000;
        din[0] = 8'hFF;
        req[0] = 1'b1;
        step();
        check("abort_busy_grant", 32'(busy), 32'd1);
        reset = 1'b1;
        req[0] = 1'b0;
        step();
        check("abort_a_ack", 32'(ack[0]), 32'd0);
        check("abort_a_dout_cleared", 32'(dout[0]), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("abort_no_late_ack", 32'(ack[0]), 32'd0);
        end
        expect_acc(1, 1'b0, 10'h000, 8'h00, 8'h11, 2);
        serve(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
